prog_mem_server: RTL

- Program/instruction memory responder on the far end of the CPU fetch interface.
- Answers the CPU's fetch requests (address plus read enable) with 16-bit instruction words.
- Provides a valid/ready load port, used by the bench or boot logic, to fill memory with a burst starting at a base address.
- Fetches are refused while a load is in progress, so the CPU never sees a half-written program.

---
 rtl/prog_mem_server.sv | 122 ++++++++++++
 1 files changed

// File: rtl/prog_mem_server.sv
// Program memory responder for the CPU fetch port, with a valid/ready burst loader.
// Fetches are refused (NOP, counted) while a burst is being written.
module prog_mem_server #(
    parameter int unsigned         DATA_W   = 16,
    parameter int unsigned         ADDR_W   = 8,
    parameter int unsigned         DEPTH    = 256,
    parameter logic [DATA_W-1:0]   NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              file_en,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_valid,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W:0]   load_len,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              load_done,
    output logic              busy,
    output logic [7:0]        drop_cnt
);

    localparam logic StIdle = 1'b0;
    localparam logic StLoad = 1'b1;

    localparam logic [ADDR_W:0] LenOne = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem [DEPTH];

    logic              state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic              done_d;
    logic              wr_en;
    logic [DATA_W-1:0] instr_d;
    logic              valid_d;
    logic [7:0]        drop_d;

    // busy and load_ready come straight off the state flop
    assign busy       = state_q;
    assign load_ready = state_q;
    assign wr_en      = (state_q == StLoad) && load_valid;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        case (state_q)
            StIdle: begin
                if (load_start) begin
                    if (load_len != '0) begin
                        wr_ptr_d    = load_base;
                        remaining_d = load_len;
                        state_d     = StLoad;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (load_valid) begin
                    wr_ptr_d    = wr_ptr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == LenOne) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        instr_d = instr_out;
        valid_d = 1'b0;
        drop_d  = drop_cnt;
        if (file_en) begin
            if (state_q == StIdle) begin
                instr_d = mem[addr];
                valid_d = 1'b1;
            end else begin
                instr_d = NOP_WORD;
                if (drop_cnt != 8'hFF) begin
                    drop_d = drop_cnt + 8'd1;
                end
            end
        end
    end

    // Memory has no reset so a mid-burst reset keeps words already written
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            remaining_q <= '0;
            load_done   <= 1'b0;
            instr_out   <= NOP_WORD;
            instr_valid <= 1'b0;
            drop_cnt    <= 8'd0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            remaining_q <= remaining_d;
            load_done   <= done_d;
            instr_out   <= instr_d;
            instr_valid <= valid_d;
            drop_cnt    <= drop_d;
        end
    end

endmodule
